// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster timing: pixel coordinates, blanking, syncs and frame strobe/count.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by one cycle to match registered RGB in the mappers.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Lead counters run one edge ahead of DrawX/DrawY, so every output is a
  // registered decode of the position it will be presented with.
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       w_h_last;
  logic       w_v_last;

  logic [9:0] r_drawx;
  logic [9:0] r_drawy;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_frame_end;
  logic [7:0] r_frame_cnt;

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_last) begin
      r_hc <= '0;
      r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_drawx     <= '0;
      r_drawy     <= '0;
      r_blank     <= 1'b1;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_frame_end <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_drawx     <= r_hc;
      r_drawy     <= r_vc;
      r_blank     <= (r_hc < H_ACT) && (r_vc < V_ACT);
      r_hs        <= !((r_hc >= H_SYNC_S) && (r_hc < H_SYNC_E));
      r_vs        <= !((r_vc >= V_SYNC_S) && (r_vc < V_SYNC_E));
      r_frame_end <= w_h_last && w_v_last;
      // Count steps together with the wrap to (0,0) that follows the strobe.
      if (r_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic r_hs_d;
  logic r_vs_d;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  assign hs = r_hs_d;
  assign vs = r_vs_d;
`else
  assign hs = r_hs;
  assign vs = r_vs;
`endif

  assign DrawX     = r_drawx;
  assign DrawY     = r_drawy;
  assign blank     = r_blank;
  assign frame_end = r_frame_end;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and a reduced
// raster instance for frame, wrap and mid-frame reset behaviour, both against an arithmetic model.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int ALIGN = 1;
`else
  localparam int ALIGN = 0;
`endif

  // Reduced raster: 20 x 10 => 200 cycles per frame.
  localparam int S_HA = 10, S_HFP = 2, S_HS = 4, S_HBP = 4;
  localparam int S_VA = 5,  S_VFP = 1, S_VS = 2, S_VBP = 2;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       blank_a, hs_a, vs_a, fe_a;
  logic       blank_b, hs_b, vs_b, fe_b;
  logic [7:0] fc_a, fc_b;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset_n(rst_a), .DrawX(x_a), .DrawY(y_a), .blank(blank_a),
    .hs(hs_a), .vs(vs_a), .frame_end(fe_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_small (
    .vga_clk(clk), .reset_n(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(blank_b),
    .hs(hs_b), .vs(vs_b), .frame_end(fe_b), .frame_cnt(fc_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Edges since reset release (-1 while in reset, -2 before the first edge).
  int k_a = -2;
  int k_b = -2;

  always @(posedge clk) begin
    k_a <= rst_a ? k_a + 1 : -1;
    k_b <= rst_b ? k_b + 1 : -1;
  end

  // Expected outputs at edge index k, purely from raster arithmetic.
  function automatic logic [31:0] model(input int k, input int ha, input int hfp, input int hsw,
                                        input int hbp, input int va, input int vfp, input int vsw,
                                        input int vbp);
    int ht, vt, x, y, kp, xp, yp, fc;
    logic bl, h, v, fe;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (k < 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    x  = k % ht;
    y  = (k / ht) % vt;
    bl = (x < ha) && (y < va);
    fe = (x == ht - 1) && (y == vt - 1);
    fc = (k / (ht * vt)) % 256;
    kp = k - ALIGN;
    if (kp < 0) begin
      h = 1'b1;
      v = 1'b1;
    end else begin
      xp = kp % ht;
      yp = (kp / ht) % vt;
      h  = !((xp >= ha + hfp) && (xp < ha + hfp + hsw));
      v  = !((yp >= va + vfp) && (yp < va + vfp + vsw));
    end
    return {x[9:0], y[9:0], bl, h, v, fe, fc[7:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got x=%0d y=%0d bl=%b hs=%b vs=%b fe=%b fc=%0d, expected x=%0d y=%0d bl=%b hs=%b vs=%b fe=%b fc=%0d",
               name, k, act[31:22], act[21:12], act[11], act[10], act[9], act[8], act[7:0],
               exp[31:22], exp[21:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (k_a >= -1)
      chk_vec("dflt", k_a, {x_a, y_a, blank_a, hs_a, vs_a, fe_a, fc_a},
              model(k_a, 640, 16, 96, 48, 480, 10, 2, 33));
    if (k_b >= -1)
      chk_vec("small", k_b, {x_b, y_b, blank_b, hs_b, vs_b, fe_b, fc_b},
              model(k_b, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP));
  end

  initial begin
    int hs_low, hs_first, vs_low, vs_first, fe_first, last_fe, wait_n, rst_n_cyc;
    hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1; fe_first = 0; last_fe = -1;

    repeat (5) @(negedge clk);
    chk("rst_x", x_a, 0);       chk("rst_y", y_a, 0);
    chk("rst_blank", blank_a, 1);
    chk("rst_hs", hs_a, 1);     chk("rst_vs", vs_a, 1);
    chk("rst_fe", fe_a, 0);     chk("rst_fc", fc_a, 0);
    chk("rst_small_hs", hs_b, 1); chk("rst_small_vs", vs_b, 1);
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int c = 0; c < 51300; c++) begin
      @(negedge clk);
      if (c < 800 && !hs_a) begin
        hs_low++;
        if (hs_first < 0) hs_first = c;
      end
      if (c < 200 && !vs_b) begin
        vs_low++;
        if (vs_first < 0) vs_first = c;
      end
      if (c < 200 && fe_b) fe_first++;
      if (fe_b) begin
        if (last_fe >= 0) chk("fe_period", c - last_fe, 200);
        last_fe = c;
      end
      case (c)
        0: begin
          chk("start_x", x_a, 0); chk("start_y", y_a, 0); chk("start_blank", blank_a, 1);
        end
        639: chk("blank_639", blank_a, 1);
        640: chk("blank_640", blank_a, 0);
        799: begin chk("x_799", x_a, 799); chk("y_799", y_a, 0); end
        800: begin chk("wrap_x", x_a, 0); chk("wrap_y", y_a, 1); end
        199: chk("small_fe_199", fe_b, 1);
        200: begin
          chk("small_fc_1", fc_b, 1); chk("small_x0", x_b, 0); chk("small_y0", y_b, 0);
        end
        51000: chk("small_fc_255", fc_b, 255);
        51200: chk("small_fc_wrap", fc_b, 0);
        default: ;
      endcase
    end
    chk("hs_low_cycles", hs_low, 96);
    chk("hs_first_low", hs_first, 656 + ALIGN);
    chk("vs_low_cycles", vs_low, 40);
    chk("vs_first_low", vs_first, 120 + ALIGN);
    chk("fe_pulses_frame0", fe_first, 1);

    // Mid-frame reset on the default instance.
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", x_a, 0); chk("mid_rst_fc", fc_a, 0); chk("mid_rst_hs", hs_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("restart_x", x_a, 0); chk("restart_y", y_a, 0); chk("restart_fc", fc_a, 0);

    // Randomized mid-frame resets on the reduced instance.
    for (int i = 0; i < 8; i++) begin
      wait_n    = $urandom_range(30, 700);
      rst_n_cyc = $urandom_range(1, 3);
      repeat (wait_n) @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      chk("small_rst_x", x_b, 0); chk("small_rst_y", y_b, 0);
      chk("small_rst_fe", fe_b, 0); chk("small_rst_fc", fc_b, 0);
      repeat (rst_n_cyc - 1) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("small_restart_x", x_b, 0); chk("small_restart_y", y_b, 0);
      chk("small_restart_fc", fc_b, 0);
    end

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
